// File: rtl/keypad_pkg.sv
// Shared key codes, debounce state type and seven-segment helpers for the keypad/display scanner.
package keypad_pkg;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;
    // Frame results carry a fifth bit so "no key" cannot alias a real code.
    localparam logic [4:0] KEY_NONE = 5'h10;

    typedef enum logic [1:0] {
        StIdle,
        StArming,
        StPressed
    } db_state_e;

    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

    // 4x3 phone layout gets its printed legends; any other geometry is row-major.
    function automatic logic [3:0] map_key(input int unsigned row, input int unsigned col,
                                           input int unsigned rows, input int unsigned cols);
        int unsigned raw;
        if (rows == 4 && cols == 3) begin
            if (row < 3)       raw = row * 3 + col + 1;
            else if (col == 0) raw = 10;
            else if (col == 1) raw = 0;
            else               raw = 11;
        end else begin
            raw = row * cols + col;
        end
        return raw[3:0];
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider: tick_o is high for one cycle every CLK_DIV clocks.
module scan_tick_gen #(
    parameter int unsigned CLK_DIV = 100000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/keypad_display_scanner.sv
// Matrix keypad scanner with debounce, digit entry buffer and multiplexed seven-segment output.
module keypad_display_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 100000,
    parameter int unsigned ROWS     = 4,
    parameter int unsigned COLS     = 3,
    parameter int unsigned DIGITS   = 8,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [COLS-1:0]   in_key,
    output logic [ROWS-1:0]   out_singal,
    output logic [DIGITS-1:0] light_code,
    output logic [6:0]        decode,
    output logic              DP_out,
    output logic              key_valid,
    output logic [3:0]        key_code,
    output logic [3:0]        digit_count
);

    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned NW = $clog2(DEBOUNCE + 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [DW-1:0] LAST_DIG = DW'(DIGITS - 1);
    localparam logic [NW-1:0] DB_MAX   = NW'(DEBOUNCE);
    localparam logic [3:0]    FULL     = 4'(DIGITS);

    logic tick;

    scan_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_i  (clk),
        .rst_i  (rst),
        .tick_o (tick)
    );

    // Row scan and frame accumulation
    logic [RW-1:0]   row_q, row_d;
    logic [ROWS-1:0] row_drive_q;
    logic            frame_hit_q;
    logic [3:0]      frame_code_q;
    logic            hit;
    logic [3:0]      hit_code;
    logic            frame_done;
    logic [4:0]      frame_res;

    always_comb begin
        hit      = 1'b0;
        hit_code = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            if (!hit && !in_key[c]) begin
                hit      = 1'b1;
                hit_code = map_key(32'(row_q), c, ROWS, COLS);
            end
        end
        row_d      = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
        frame_done = tick && (row_q == LAST_ROW);
        if (frame_hit_q) frame_res = {1'b0, frame_code_q};
        else if (hit)    frame_res = {1'b0, hit_code};
        else             frame_res = KEY_NONE;
    end

    // Debounce next-state
    db_state_e   db_state_q, db_state_d;
    logic [3:0]  db_key_q, db_key_d;
    logic [NW-1:0] db_cnt_q, db_cnt_d, arm_cnt;
    logic        fire;

    always_comb begin
        db_state_d = db_state_q;
        db_key_d   = db_key_q;
        db_cnt_d   = db_cnt_q;
        arm_cnt    = '0;
        fire       = 1'b0;
        if (frame_done) begin
            unique case (db_state_q)
                StIdle, StArming: begin
                    if (frame_res == KEY_NONE) begin
                        db_state_d = StIdle;
                        db_cnt_d   = '0;
                    end else begin
                        arm_cnt  = (db_state_q == StArming && frame_res[3:0] == db_key_q)
                                   ? db_cnt_q + 1'b1 : NW'(1);
                        db_key_d = frame_res[3:0];
                        if (arm_cnt == DB_MAX) begin
                            db_state_d = StPressed;
                            db_cnt_d   = '0;
                            fire       = 1'b1;
                        end else begin
                            db_state_d = StArming;
                            db_cnt_d   = arm_cnt;
                        end
                    end
                end
                StPressed: begin
                    if (frame_res != KEY_NONE) begin
                        db_cnt_d = '0;
                    end else if (db_cnt_q + 1'b1 == DB_MAX) begin
                        db_state_d = StIdle;
                        db_cnt_d   = '0;
                    end else begin
                        db_cnt_d = db_cnt_q + 1'b1;
                    end
                end
                default: db_state_d = StIdle;
            endcase
        end
    end

    logic       key_valid_q;
    logic [3:0] key_code_q;

    // Reset lands in StPressed so a key held through reset must be released first.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q        <= '0;
            row_drive_q  <= ~ROWS'(1);
            frame_hit_q  <= 1'b0;
            frame_code_q <= '0;
            db_state_q   <= StPressed;
            db_key_q     <= '0;
            db_cnt_q     <= '0;
            key_valid_q  <= 1'b0;
            key_code_q   <= '0;
        end else begin
            db_state_q  <= db_state_d;
            db_key_q    <= db_key_d;
            db_cnt_q    <= db_cnt_d;
            key_valid_q <= fire;
            if (fire) key_code_q <= frame_res[3:0];
            if (tick) begin
                row_q       <= row_d;
                row_drive_q <= ~(ROWS'(1) << row_d);
                if (frame_done) begin
                    frame_hit_q <= 1'b0;
                end else if (!frame_hit_q && hit) begin
                    frame_hit_q  <= 1'b1;
                    frame_code_q <= hit_code;
                end
            end
        end
    end

    // Entry buffer: index 0 is the newest digit
    logic [3:0] digits_q [DIGITS];
    logic [3:0] count_q;
    logic       ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DIGITS; i++) digits_q[i] <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (fire) begin
            if (frame_res[3:0] <= 4'd9) begin
                digits_q[0] <= frame_res[3:0];
                for (int unsigned i = 1; i < DIGITS; i++) digits_q[i] <= digits_q[i-1];
                if (count_q == FULL) ovf_q   <= 1'b1;
                else                 count_q <= count_q + 1'b1;
            end else if (frame_res[3:0] == KEY_HASH) begin
                for (int unsigned i = 0; i + 1 < DIGITS; i++) digits_q[i] <= digits_q[i+1];
                digits_q[DIGITS-1] <= '0;
                if (count_q != 4'd0) count_q <= count_q - 1'b1;
            end else if (frame_res[3:0] == KEY_STAR) begin
                for (int unsigned i = 0; i < DIGITS; i++) digits_q[i] <= '0;
                count_q <= '0;
                ovf_q   <= 1'b0;
            end
        end
    end

    // Display multiplexer
    logic [DW-1:0]     dig_q, dig_d;
    logic [DIGITS-1:0] light_q;
    logic [6:0]        seg_q;
    logic              dp_q;

    always_comb begin
        dig_d = (dig_q == LAST_DIG) ? '0 : dig_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dig_q   <= '0;
            light_q <= DIGITS'(1);
            seg_q   <= '0;
            dp_q    <= 1'b0;
        end else if (tick) begin
            dig_q   <= dig_d;
            light_q <= DIGITS'(1) << dig_d;
            seg_q   <= (4'(dig_d) < count_q) ? seg7(digits_q[dig_d]) : 7'b0;
            dp_q    <= (dig_d == LAST_DIG) && ovf_q;
        end
    end

    assign out_singal  = row_drive_q;
    assign light_code  = light_q;
    assign decode      = seg_q;
    assign DP_out      = dp_q;
    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign digit_count = count_q;

endmodule
